// File: rtl/tag_alloc_ctrl.sv
// Tag allocation controller: dual-grant allocation from the tag free list, a small freed-tag
// queue drained one tag per cycle into the free list, and a drain handshake for recovery.
// Optional build macro TAG_ALLOC_PERF_EN adds the stall_cycles / free_q_full_cycles counters.
module tag_alloc_ctrl #(
    parameter int NUM_TAGS     = 128,
    parameter int TAG_W        = $clog2(NUM_TAGS) + 1,
    parameter int FREE_Q_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_valid_0,
    input  logic             alloc_valid_1,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag_0,
    output logic [TAG_W-1:0] alloc_tag_1,
    input  logic             free_valid_0,
    input  logic [TAG_W-1:0] free_tag_0,
    input  logic             free_valid_1,
    input  logic [TAG_W-1:0] free_tag_1,
    output logic             free_ready,
    input  logic             drain_req,
    output logic             drain_done,
    input  logic [TAG_W-1:0] fl_num_items,
    input  logic [TAG_W-1:0] fl_tag_0,
    input  logic [TAG_W-1:0] fl_tag_1,
    output logic             fl_read_1,
    output logic             fl_read_2,
    output logic             fl_write,
    output logic [TAG_W-1:0] fl_write_tag
`ifdef TAG_ALLOC_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      free_q_full_cycles
`endif
);

    localparam int PTR_W = (FREE_Q_DEPTH > 1) ? $clog2(FREE_Q_DEPTH) : 1;
    localparam int CNT_W = $clog2(FREE_Q_DEPTH) + 1;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    state_t mode;

    logic [TAG_W-1:0] q_mem [FREE_Q_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             active;
    logic [1:0]       need;
    logic             enq_0;
    logic             enq_1;
    logic [CNT_W-1:0] enq_cnt;
    logic [PTR_W-1:0] wr_ptr_1;

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values of the others, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // drain_req acts in the cycle it changes, so outputs follow the state being entered
    // (mode) rather than the registered one.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned,
        // which would otherwise infer a latch.
        mode    = INIT;
        state_d = state_q;
        case (state_q)
            INIT: begin
                mode    = INIT;
                state_d = RUN;
            end
            RUN, DRAIN: begin
                mode    = drain_req ? DRAIN : RUN;
                state_d = mode;
            end
            default: begin
                mode    = INIT;
                state_d = INIT;
            end
        endcase
    end

    always_comb begin
        active       = !reset && (mode != INIT);
        need         = {1'b0, alloc_valid_0} + {1'b0, alloc_valid_1};

        alloc_ready  = active && (mode == RUN) && alloc_valid_0
                       && (fl_num_items >= TAG_W'(need));
        fl_read_1    = alloc_ready && !alloc_valid_1;
        fl_read_2    = alloc_ready && alloc_valid_1;
        alloc_tag_0  = reset ? '0 : fl_tag_0;
        alloc_tag_1  = reset ? '0 : fl_tag_1;

        free_ready   = active && (count <= CNT_W'(FREE_Q_DEPTH - 2));
        fl_write     = active && (count != '0);
        fl_write_tag = fl_write ? q_mem[rd_ptr] : '0;
        drain_done   = active && (mode == DRAIN) && (count == '0)
                       && !free_valid_0 && !free_valid_1;

        enq_0        = free_ready && free_valid_0;
        enq_1        = free_ready && free_valid_1;
        enq_cnt      = CNT_W'(enq_0) + CNT_W'(enq_1);
        wr_ptr_1     = wr_ptr + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(enq_cnt);
            rd_ptr <= rd_ptr + PTR_W'(fl_write);
            count  <= count + enq_cnt - CNT_W'(fl_write);
        end
    end

    // NOTE: queue storage has no reset; entries are only read once count marks them valid,
    // and reset clears count and pointers, which discards anything still queued.
    always_ff @(posedge clk) begin
        if (enq_0) begin
            q_mem[wr_ptr] <= free_tag_0;
        end
        if (enq_1) begin
            q_mem[enq_0 ? wr_ptr_1 : wr_ptr] <= free_tag_1;
        end
    end

`ifdef TAG_ALLOC_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles       <= '0;
            free_q_full_cycles <= '0;
        end else begin
            if ((mode == RUN) && alloc_valid_0 && !alloc_ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if ((mode != INIT) && !free_ready && (free_q_full_cycles != '1)) begin
                free_q_full_cycles <= free_q_full_cycles + 32'd1;
            end
        end
    end
`endif

    a_slot1_needs_slot0: assert property (@(posedge clk) disable iff (reset)
        !(alloc_valid_1 && !alloc_valid_0));

    a_free_only_when_ready: assert property (@(posedge clk) disable iff (reset)
        (free_valid_0 || free_valid_1) |-> free_ready);

    a_fl_count_in_range: assert property (@(posedge clk) disable iff (reset)
        fl_num_items <= TAG_W'(NUM_TAGS));

endmodule

// File: tb/tb_tag_alloc_ctrl.sv
// Self-checking bench for tag_alloc_ctrl: queue-based reference model compared every cycle,
// plus directed literal expectations for the documented scenarios.
module tb_tag_alloc_ctrl;

    localparam int TW = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          alloc_valid_0, alloc_valid_1, alloc_ready;
    logic [TW-1:0] alloc_tag_0, alloc_tag_1;
    logic          free_valid_0, free_valid_1, free_ready;
    logic [TW-1:0] free_tag_0, free_tag_1;
    logic          drain_req, drain_done;
    logic [TW-1:0] fl_num_items, fl_tag_0, fl_tag_1;
    logic          fl_read_1, fl_read_2, fl_write;
    logic [TW-1:0] fl_write_tag;
`ifdef TAG_ALLOC_PERF_EN
    logic [31:0]   stall_cycles, free_q_full_cycles;
`endif

    tag_alloc_ctrl #(.NUM_TAGS(128), .TAG_W(TW), .FREE_Q_DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid_0(alloc_valid_0), .alloc_valid_1(alloc_valid_1),
        .alloc_ready(alloc_ready), .alloc_tag_0(alloc_tag_0), .alloc_tag_1(alloc_tag_1),
        .free_valid_0(free_valid_0), .free_tag_0(free_tag_0),
        .free_valid_1(free_valid_1), .free_tag_1(free_tag_1), .free_ready(free_ready),
        .drain_req(drain_req), .drain_done(drain_done),
        .fl_num_items(fl_num_items), .fl_tag_0(fl_tag_0), .fl_tag_1(fl_tag_1),
        .fl_read_1(fl_read_1), .fl_read_2(fl_read_2),
        .fl_write(fl_write), .fl_write_tag(fl_write_tag)
`ifdef TAG_ALLOC_PERF_EN
        , .stall_cycles(stall_cycles), .free_q_full_cycles(free_q_full_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_freed  = 0;
    int n_written = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: phase 0 = before any reset, 1 = first cycle after reset, 2 = operating.
    int            phase = 0;
    logic [TW-1:0] mq[$];

    function automatic bit model_ready();
        return (phase == 2) && (mq.size() <= D - 2);
    endfunction

    always @(negedge clk) begin
        int   need;
        logic e_ar, e_fr, e_fw, e_dd;
        if (reset) begin
            check("rst_alloc_ready", alloc_ready, 0);
            check("rst_fl_read", {fl_read_2, fl_read_1}, 0);
            check("rst_alloc_tags", {alloc_tag_1, alloc_tag_0}, 0);
            check("rst_free_ready", free_ready, 0);
            check("rst_fl_write", fl_write, 0);
            check("rst_fl_write_tag", fl_write_tag, 0);
            check("rst_drain_done", drain_done, 0);
            mq.delete();
            phase = 1;
        end else if (phase == 1) begin
            check("init_alloc_ready", alloc_ready, 0);
            check("init_fl_read", {fl_read_2, fl_read_1}, 0);
            check("init_free_ready", free_ready, 0);
            check("init_fl_write", fl_write, 0);
            check("init_drain_done", drain_done, 0);
            check("init_alloc_tags", {alloc_tag_1, alloc_tag_0}, {fl_tag_1, fl_tag_0});
            phase = 2;
        end else if (phase == 2) begin
            need = int'(alloc_valid_0) + int'(alloc_valid_1);
            e_ar = alloc_valid_0 && !drain_req && (int'(fl_num_items) >= need);
            e_fr = (mq.size() <= D - 2);
            e_fw = (mq.size() != 0);
            e_dd = drain_req && (mq.size() == 0) && !free_valid_0 && !free_valid_1;
            check("m_alloc_ready", alloc_ready, e_ar);
            check("m_fl_read_1", fl_read_1, e_ar && !alloc_valid_1);
            check("m_fl_read_2", fl_read_2, e_ar && alloc_valid_1);
            check("m_alloc_tags", {alloc_tag_1, alloc_tag_0}, {fl_tag_1, fl_tag_0});
            check("m_free_ready", free_ready, e_fr);
            check("m_fl_write", fl_write, e_fw);
            check("m_drain_done", drain_done, e_dd);
            if (fl_write === 1'b1) n_written++;
            if (e_fw) begin
                check("m_fl_write_tag", fl_write_tag, mq[0]);
                void'(mq.pop_front());
            end
            if (e_fr) begin
                if (free_valid_0) mq.push_back(free_tag_0);
                if (free_valid_1) mq.push_back(free_tag_1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic free_two(input logic [TW-1:0] t0, input logic [TW-1:0] t1);
        free_valid_0 = 1'b1; free_tag_0 = t0;
        free_valid_1 = 1'b1; free_tag_1 = t1;
        n_freed += 2;
    endtask

    task automatic no_free();
        free_valid_0 = 1'b0;
        free_valid_1 = 1'b0;
    endtask

    initial begin
        logic [TW-1:0] next_tag;
        int            guard;
        reset = 1'b1;
        alloc_valid_0 = 1'b0; alloc_valid_1 = 1'b0;
        free_valid_0 = 1'b0; free_valid_1 = 1'b0; free_tag_0 = '0; free_tag_1 = '0;
        drain_req = 1'b0;
        fl_num_items = 8'd128; fl_tag_0 = 8'd0; fl_tag_1 = 8'd1;

        repeat (3) @(posedge clk);
        #1;
        // First cycle out of reset: no grant yet.
        reset = 1'b0;
        alloc_valid_0 = 1'b1; alloc_valid_1 = 1'b1;
        #2;
        check("t1_init_no_grant", alloc_ready, 0);
        check("t1_init_no_read2", fl_read_2, 0);
        tick();
        #2;
        check("t1_run_grant", alloc_ready, 1);
        check("t1_run_read2", fl_read_2, 1);
        check("t1_run_tags", {alloc_tag_1, alloc_tag_0}, 16'h0100);

        // Occupancy boundary: one tag left.
        tick();
        fl_num_items = 8'd1;
        #2;
        check("t2_short_no_grant", alloc_ready, 0);
        check("t2_short_no_read", {fl_read_2, fl_read_1}, 0);
        alloc_valid_1 = 1'b0;
        #1;
        check("t2_single_grant", alloc_ready, 1);
        check("t2_single_read1", {fl_read_2, fl_read_1}, 2'b01);

        // Two frees into an empty queue drain in order.
        tick();
        alloc_valid_0 = 1'b0; fl_num_items = 8'd128;
        free_two(8'h12, 8'h34);
        tick();
        no_free();
        #2;
        check("t3_write_first", {fl_write, fl_write_tag}, {1'b1, 8'h12});
        tick();
        #2;
        check("t3_write_second", {fl_write, fl_write_tag}, {1'b1, 8'h34});
        tick();
        #2;
        check("t3_empty_again", {fl_write, free_ready}, 2'b01);

        // Sustained double frees: queue fills, pointers wrap.
        next_tag = 8'h40;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (model_ready()) begin
                free_two(next_tag, next_tag + 8'd1);
                next_tag = next_tag + 8'd2;
            end else begin
                no_free();
            end
            if (i == 2) begin
                #2;
                check("t4_full_not_ready", free_ready, 0);
            end
        end
        tick();
        no_free();
        guard = 0;
        while (mq.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("t4_drain_timeout", guard < 20, 1);

        // Drain with three queued tags.
        tick();
        free_two(8'h70, 8'h71);
        tick();
        free_two(8'h72, 8'h73);
        tick();
        no_free();
        drain_req = 1'b1; alloc_valid_0 = 1'b1; alloc_valid_1 = 1'b0;
        #2;
        check("t5_drain_blocks_alloc", alloc_ready, 0);
        check("t5_drain_not_done", drain_done, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            #2;
            check($sformatf("t5_drain_done_c%0d", k), drain_done, (k == 3) ? 1 : 0);
        end
        tick();
        drain_req = 1'b0;
        #2;
        check("t5_resume_grant", {alloc_ready, fl_read_1}, 2'b11);
        check("t5_resume_not_done", drain_done, 0);
        check("t5_no_tag_lost", n_written, n_freed);

        // Reset with queued tags while draining.
        tick();
        alloc_valid_0 = 1'b0;
        fl_tag_0 = 8'h55; fl_tag_1 = 8'h66;
        free_two(8'h80, 8'h81);
        tick();
        no_free();
        reset = 1'b1; drain_req = 1'b1; alloc_valid_0 = 1'b1;
        #2;
        check("t6_rst_outputs", {alloc_ready, free_ready, fl_write, drain_done}, 0);
        check("t6_rst_tag", alloc_tag_0, 0);
        tick();
        tick();
        reset = 1'b0; drain_req = 1'b0;
        #2;
        check("t6_init_no_grant", alloc_ready, 0);
        check("t6_init_no_write", fl_write, 0);
        tick();
        #2;
        check("t6_run_grant", alloc_ready, 1);
        check("t6_queue_discarded", {fl_write, free_ready}, 2'b01);
        check("t6_run_tag", alloc_tag_0, 8'h55);

        tick();
        alloc_valid_0 = 1'b0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
